// File: rtl/sprom_loader.sv
// Packs a byte stream into data_width words and writes them to consecutive memory addresses.
// Latency: the write strobe comes one cycle after a word's last byte; each write adds one bubble cycle.
// Backpressure: in_ready is registered, is high only while collecting, and a stalled source is waited on indefinitely.
module sprom_loader #(
    parameter int addr_width = 8,
    parameter int data_width = 8,
    parameter int length     = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [addr_width-1:0] start_addr,
    input  logic [addr_width:0]   word_count,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [addr_width-1:0] mem_addr,
    output logic [data_width-1:0] mem_data,
    output logic                  mem_we,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [7:0]            checksum
);
    localparam int                  bytes_per_word = data_width / 8;
    localparam int                  aw1            = addr_width + 1;
    localparam logic [1:0]          last_byte      = 2'(bytes_per_word - 1);
    localparam logic [addr_width:0] len_v          = aw1'(length);
    localparam logic [addr_width-1:0] last_addr    = addr_width'(length - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t                state;
    logic [addr_width-1:0] cur_addr;
    logic [addr_width:0]   remaining;
    logic [1:0]            byte_idx;
    logic [data_width-1:0] word_buf;
    logic [data_width-1:0] word_next;
    logic                  xfer;

    assign xfer = in_valid && in_ready;

    // Current partial word with the incoming byte merged into its little-endian lane.
    always_comb begin
        word_next = word_buf;
        for (int b = 0; b < bytes_per_word; b++) begin
            if (2'(b) == byte_idx) begin
                word_next[b*8 +: 8] = in_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            byte_idx  <= '0;
            word_buf  <= '0;
            in_ready  <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            checksum  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        cur_addr  <= start_addr;
                        remaining <= word_count;
                        byte_idx  <= '0;
                        checksum  <= '0;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        if ({1'b0, start_addr} >= len_v) begin
                            state <= DONE;
                            done  <= 1'b1;
                            error <= 1'b1;
                        end else if (word_count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= COLLECT;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (xfer) begin
                        checksum <= checksum + in_data;
                        word_buf <= word_next;
                        if (byte_idx == last_byte) begin
                            byte_idx <= '0;
                            state    <= WRITE;
                            in_ready <= 1'b0;
                            mem_we   <= 1'b1;
                            mem_addr <= cur_addr;
                            mem_data <= word_next;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    mem_we    <= 1'b0;
                    cur_addr  <= (cur_addr == last_addr) ? '0 : cur_addr + 1'b1;
                    remaining <= remaining - 1'b1;
                    if (remaining == aw1'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state    <= COLLECT;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprom_loader.sv
// Directed bench: an 8-bit/256-word loader and a 16-bit/200-word loader share clock and reset.
module tb_sprom_loader;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic       a_start = 1'b0, a_in_valid = 1'b0, a_in_ready, a_mem_we, a_busy, a_done, a_error;
    logic [7:0] a_start_addr = '0, a_in_data = '0, a_mem_addr, a_mem_data, a_checksum;
    logic [8:0] a_word_count = '0;

    logic        b_start = 1'b0, b_in_valid = 1'b0, b_in_ready, b_mem_we, b_busy, b_done, b_error;
    logic [7:0]  b_start_addr = '0, b_in_data = '0, b_mem_addr, b_checksum;
    logic [15:0] b_mem_data;
    logic [8:0]  b_word_count = '0;

    sprom_loader u_a (
        .clock(clock), .reset(reset), .start(a_start), .start_addr(a_start_addr),
        .word_count(a_word_count), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .mem_addr(a_mem_addr), .mem_data(a_mem_data),
        .mem_we(a_mem_we), .busy(a_busy), .done(a_done), .error(a_error),
        .checksum(a_checksum)
    );

    sprom_loader #(.addr_width(8), .data_width(16), .length(200)) u_b (
        .clock(clock), .reset(reset), .start(b_start), .start_addr(b_start_addr),
        .word_count(b_word_count), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .mem_addr(b_mem_addr), .mem_data(b_mem_data),
        .mem_we(b_mem_we), .busy(b_busy), .done(b_done), .error(b_error),
        .checksum(b_checksum)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [31:0] a_wa[$], a_wd[$], b_wa[$], b_wd[$];
    int a_wc[$], b_wc[$];

    always @(posedge clock) cyc <= cyc + 1;

    // Write log, sampled mid-cycle
    always @(negedge clock) begin
        if (a_mem_we) begin
            a_wa.push_back(32'(a_mem_addr));
            a_wd.push_back(32'(a_mem_data));
            a_wc.push_back(cyc);
        end
        if (b_mem_we) begin
            b_wa.push_back(32'(b_mem_addr));
            b_wd.push_back(32'(b_mem_data));
            b_wc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic clr();
        a_wa.delete(); a_wd.delete(); a_wc.delete();
        b_wa.delete(); b_wd.delete(); b_wc.delete();
    endtask

    task automatic go(input bit to_b, input logic [7:0] sa, input logic [8:0] wc);
        if (to_b) begin
            b_start = 1'b1; b_start_addr = sa; b_word_count = wc;
        end else begin
            a_start = 1'b1; a_start_addr = sa; a_word_count = wc;
        end
        tick();
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    task automatic send(input bit to_b, input logic [7:0] d, output int acc);
        logic rdy;
        acc = -1;
        if (to_b) begin
            b_in_valid = 1'b1; b_in_data = d;
        end else begin
            a_in_valid = 1'b1; a_in_data = d;
        end
        for (int k = 0; k < 50; k++) begin
            rdy = to_b ? b_in_ready : a_in_ready;
            tick();
            if (rdy) begin
                acc = cyc;
                break;
            end
        end
        chk("byte_accepted", 32'(acc >= 0), 1);
    endtask

    task automatic wait_done(input bit to_b);
        for (int k = 0; k < 100; k++) begin
            if (to_b ? b_done : a_done) break;
            tick();
        end
        chk("done_reached", 32'(to_b ? b_done : a_done), 1);
    endtask

    task automatic chk_wr(input bit to_b, input int i, input logic [31:0] ea, input logic [31:0] ed);
        int sz;
        sz = to_b ? b_wa.size() : a_wa.size();
        if (i < sz) begin
            chk("wr_addr", to_b ? b_wa[i] : a_wa[i], ea);
            chk("wr_data", to_b ? b_wd[i] : a_wd[i], ed);
        end else begin
            chk("wr_count_short", 32'(sz), 32'(i + 1));
        end
    endtask

    int t0, t1, t2, t3;

    initial begin
        tick(2);
        chk("rst_in_ready", 32'(a_in_ready), 0);
        chk("rst_mem_we",   32'(a_mem_we), 0);
        chk("rst_busy",     32'(a_busy), 0);
        chk("rst_done",     32'(a_done), 0);
        chk("rst_error",    32'(a_error), 0);
        chk("rst_mem_addr", 32'(a_mem_addr), 0);
        chk("rst_mem_data", 32'(b_mem_data), 0);
        chk("rst_checksum", 32'(a_checksum), 0);
        reset = 1'b0;
        tick();

        // Three 8-bit words from 0x10, continuous source
        clr();
        go(0, 8'h10, 9'd3);
        chk("s1_busy", 32'(a_busy), 1);
        chk("s1_in_ready", 32'(a_in_ready), 1);
        send(0, 8'h11, t0);
        send(0, 8'h22, t1);
        send(0, 8'h33, t2);
        a_in_valid = 1'b0;
        wait_done(0);
        chk("s1_nwrites", 32'(a_wa.size()), 3);
        chk_wr(0, 0, 'h10, 'h11);
        chk_wr(0, 1, 'h11, 'h22);
        chk_wr(0, 2, 'h12, 'h33);
        chk("s1_checksum", 32'(a_checksum), 'h66);
        chk("s1_error", 32'(a_error), 0);
        chk("s1_busy_end", 32'(a_busy), 0);
        chk("s1_spacing", (a_wc.size() == 3) ? 32'(a_wc[2] - a_wc[1]) : 32'hFFFF_FFFF, 2);

        // Address wrap 0xFF -> 0x00, then outputs hold
        clr();
        go(0, 8'hFF, 9'd2);
        send(0, 8'hA5, t0);
        send(0, 8'h5A, t1);
        a_in_valid = 1'b0;
        wait_done(0);
        chk_wr(0, 0, 'hFF, 'hA5);
        chk_wr(0, 1, 'h00, 'h5A);
        chk("s2_checksum", 32'(a_checksum), 'hFF);
        tick(3);
        chk("s2_hold_addr", 32'(a_mem_addr), 'h00);
        chk("s2_hold_data", 32'(a_mem_data), 'h5A);
        chk("s2_we_idle", 32'(a_mem_we), 0);

        // Zero-length load and out-of-range start
        clr();
        go(0, 8'h00, 9'd0);
        chk("s3_done", 32'(a_done), 1);
        chk("s3_error", 32'(a_error), 0);
        chk("s3_checksum_clr", 32'(a_checksum), 0);
        go(1, 8'd200, 9'd1);
        chk("s3b_done", 32'(b_done), 1);
        chk("s3b_error", 32'(b_error), 1);
        chk("s3b_in_ready", 32'(b_in_ready), 0);
        tick(3);
        chk("s3_no_writes", 32'(a_wa.size() + b_wa.size()), 0);

        // 16-bit little-endian words; strobe one cycle after the closing byte
        clr();
        go(1, 8'h00, 9'd2);
        chk("s4_error_clr", 32'(b_error), 0);
        send(1, 8'h34, t0);
        send(1, 8'h12, t1);
        send(1, 8'h78, t2);
        send(1, 8'h56, t3);
        b_in_valid = 1'b0;
        wait_done(1);
        chk("s4_nwrites", 32'(b_wa.size()), 2);
        chk_wr(1, 0, 'h00, 'h1234);
        chk_wr(1, 1, 'h01, 'h5678);
        chk("s4_we0_time", (b_wc.size() == 2) ? 32'(b_wc[0]) : 32'hFFFF_FFFF, 32'(t1));
        chk("s4_we1_time", (b_wc.size() == 2) ? 32'(b_wc[1]) : 32'hFFFF_FFFF, 32'(t3));
        chk("s4_spacing", (b_wc.size() == 2) ? 32'(b_wc[1] - b_wc[0]) : 32'hFFFF_FFFF, 3);

        // Wrap at length-1 = 199
        clr();
        go(1, 8'd199, 9'd2);
        send(1, 8'h01, t0);
        send(1, 8'h02, t0);
        send(1, 8'h03, t0);
        send(1, 8'h04, t0);
        b_in_valid = 1'b0;
        wait_done(1);
        chk_wr(1, 0, 199, 'h0201);
        chk_wr(1, 1, 0, 'h0403);

        // Mid-word stall of 10 cycles with a stray start
        clr();
        go(1, 8'h05, 9'd1);
        send(1, 8'hCD, t0);
        b_in_valid = 1'b0;
        tick(4);
        go(1, 8'h77, 9'd5);
        tick(5);
        chk("s5_busy", 32'(b_busy), 1);
        chk("s5_in_ready", 32'(b_in_ready), 1);
        chk("s5_no_write", 32'(b_wa.size()), 0);
        send(1, 8'hAB, t1);
        b_in_valid = 1'b0;
        wait_done(1);
        chk("s5_nwrites", 32'(b_wa.size()), 1);
        chk_wr(1, 0, 'h05, 'hABCD);
        chk("s5_checksum", 32'(b_checksum), 'h78);

        // Reset mid-word, together with start, then a clean reload
        clr();
        go(1, 8'h10, 9'd2);
        send(1, 8'hEE, t0);
        b_in_valid = 1'b0;
        reset = 1'b1;
        b_start = 1'b1;
        tick();
        chk("s6_in_ready", 32'(b_in_ready), 0);
        chk("s6_mem_we", 32'(b_mem_we), 0);
        chk("s6_busy", 32'(b_busy), 0);
        chk("s6_done", 32'(b_done), 0);
        chk("s6_error", 32'(b_error), 0);
        chk("s6_mem_addr", 32'(b_mem_addr), 0);
        chk("s6_mem_data", 32'(b_mem_data), 0);
        chk("s6_checksum", 32'(b_checksum), 0);
        reset = 1'b0;
        b_start = 1'b0;
        tick();
        chk("s6_no_write", 32'(b_wa.size()), 0);
        go(1, 8'h20, 9'd1);
        send(1, 8'h22, t0);
        send(1, 8'h11, t1);
        b_in_valid = 1'b0;
        wait_done(1);
        chk("s6_nwrites", 32'(b_wa.size()), 1);
        chk_wr(1, 0, 'h20, 'h1122);
        chk("s6_checksum_new", 32'(b_checksum), 'h33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sprom_loader.md
SPROM_LOADER -- requirements
Module: sprom_loader

Interface
REQ-001 The module SHALL take parameter addr_width, default 8, which is the memory address width in bits.
REQ-002 The module SHALL take parameter data_width, default 8, which is the memory word width in bits; it SHALL be a multiple of 8 in the range 8..32.
REQ-003 The module SHALL take parameter length, default 256, which is the number of words in the target memory.
REQ-004 Port clock: input, 1 bit; the single clock, and all logic SHALL be rising-edge.
REQ-005 Port reset: input, 1 bit; synchronous, active-high reset.
REQ-006 Port start: input, 1 bit; one-cycle load request.
REQ-007 Port start_addr: input, addr_width bits; first word address of the load.
REQ-008 Port word_count: input, addr_width+1 bits; number of words to write.
REQ-009 Port in_data: input, 8 bits; byte stream data.
REQ-010 Port in_valid: input, 1 bit; the byte on in_data is valid.
REQ-011 Port in_ready: output, 1 bit; the loader accepts a byte this cycle.
REQ-012 Port mem_addr: output, addr_width bits; memory write address.
REQ-013 Port mem_data: output, data_width bits; memory write data.
REQ-014 Port mem_we: output, 1 bit; memory write strobe.
REQ-015 Port busy: output, 1 bit; a load is in progress.
REQ-016 Port done: output, 1 bit; the last load has finished.
REQ-017 Port error: output, 1 bit; the last start was rejected.
REQ-018 Port checksum: output, 8 bits; mod-256 sum of the bytes accepted since the last start.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, COLLECT, WRITE, DONE.
REQ-020 When start=1 in IDLE or DONE, the block SHALL latch start_addr and word_count, clear checksum, done and error, and select the next state as follows.
- start_addr >= length: go to DONE with error=1 and perform no writes.
- word_count = 0: go to DONE with error=0 and perform no writes.
- Otherwise: go to COLLECT.
REQ-021 When start=1 in COLLECT or WRITE, the block SHALL ignore it with no state change.
REQ-022 A byte SHALL transfer only on a cycle where in_valid=1 and in_ready=1.
REQ-023 in_ready SHALL be 1 only in COLLECT, and SHALL not depend combinationally on in_valid.
REQ-024 Bytes SHALL assemble little-endian: the first byte of a word goes to bits [7:0], the next to [15:8], and so on; data_width/8 bytes make one word.
REQ-025 Each accepted byte SHALL be added to checksum mod 256 in the cycle after the transfer.
REQ-026 On acceptance of a word's final byte, the FSM SHALL enter WRITE on the next cycle.
REQ-027 In WRITE, mem_we SHALL be 1 for exactly one cycle, with mem_addr equal to the current address and mem_data equal to the assembled word; mem_we SHALL be 0 in every other state.
REQ-028 After each write the address SHALL increment, wrapping from length-1 to 0, and the remaining-word count SHALL decrement.
REQ-029 After a write, if the remaining count is 0 the FSM SHALL go to DONE; otherwise it SHALL go to COLLECT.
REQ-030 Throughput SHALL be one word per data_width/8 + 1 cycles when the source is always valid; the WRITE cycle is a mandatory bubble.
REQ-031 busy SHALL equal 1 exactly in COLLECT and WRITE.
REQ-032 done SHALL be 1 in DONE and SHALL hold until the next accepted start or reset.
REQ-033 error SHALL hold until the next accepted start or reset.
REQ-034 in_valid=0 mid-word SHALL stall collection indefinitely with no timeout, and partial bytes SHALL be kept.
REQ-035 mem_addr and mem_data SHALL hold their last values outside WRITE.

Reset
REQ-036 reset=1 SHALL force IDLE on the next edge from any state, discarding partial words, with no write issued.
REQ-037 Reset values SHALL be:
- in_ready=0, mem_we=0, busy=0, done=0, error=0
- mem_addr=0, mem_data=0, checksum=0
REQ-038 reset SHALL take priority over start.

Verification
REQ-039 Scenario: data_width=8, start_addr=0x10, word_count=3, bytes 0x11,0x22,0x33 continuous -> writes (0x10,0x11), (0x11,0x22), (0x12,0x33); checksum=0x66; done=1.
REQ-040 Scenario: data_width=16, start_addr=0, word_count=2, bytes 0x34,0x12,0x78,0x56 -> writes (0,0x1234), (1,0x5678); each mem_we occurs 1 cycle after the second byte of its word.
REQ-041 Scenario: length=256, start_addr=0xFF, word_count=2 -> writes to 0xFF, then 0x00.
REQ-042 Scenario: start with start_addr=length, and separately with word_count=0 -> error=1 and 0 respectively, done=1, mem_we never asserted.
REQ-043 Scenario: in_valid held low for 10 cycles mid-word, plus a start pulse in COLLECT -> no write, no restart; the correct word is written once the stream resumes.
REQ-044 Scenario: reset asserted in COLLECT after 1 of 2 bytes -> all outputs at reset values next cycle; a new load writes its words correctly with no stale bytes.
